// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 word shift/rotate execution stage.
package fx2_pkg;

  localparam int WORD_W = 32;
  localparam int QUAD_W = 128;

  localparam logic [2:0] FX2_SHL   = 3'd0;
  localparam logic [2:0] FX2_SHLI  = 3'd1;
  localparam logic [2:0] FX2_ROT   = 3'd2;
  localparam logic [2:0] FX2_ROTI  = 3'd3;
  localparam logic [2:0] FX2_ROTM  = 3'd4;
  localparam logic [2:0] FX2_ROTMI = 3'd5;

endpackage

// File: rtl/fx2_word_shift.sv
// Combinational shift/rotate of one 32-bit word; cnt_i is the operand-B count field.
module fx2_word_shift
  import fx2_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [2:0]        op_i,
  input  logic [5:0]        cnt_i,
  input  logic [6:0]        imm_i,
  output logic [WORD_W-1:0] res_o
);

  function automatic logic [WORD_W-1:0] shl_word(input logic [WORD_W-1:0] w,
                                                 input logic [5:0] s);
    return s[5] ? '0 : (w << s[4:0]);
  endfunction

  function automatic logic [WORD_W-1:0] shr_word(input logic [WORD_W-1:0] w,
                                                 input logic [5:0] s);
    return s[5] ? '0 : (w >> s[4:0]);
  endfunction

  function automatic logic [WORD_W-1:0] rotl_word(input logic [WORD_W-1:0] w,
                                                  input logic [4:0] r);
    logic [2*WORD_W-1:0] t;
    t = {w, w} << r;
    return t[2*WORD_W-1:WORD_W];
  endfunction

  // Sign extension of the immediate never reaches the low six count bits.
  logic       unused_imm;
  assign unused_imm = imm_i[6];

  always_comb begin
    res_o = '0;
    case (op_i)
      FX2_SHL:   res_o = shl_word(word_i, cnt_i);
      FX2_SHLI:  res_o = shl_word(word_i, imm_i[5:0]);
      FX2_ROT:   res_o = rotl_word(word_i, cnt_i[4:0]);
      FX2_ROTI:  res_o = rotl_word(word_i, imm_i[4:0]);
      FX2_ROTM:  res_o = shr_word(word_i, 6'd0 - cnt_i);
      FX2_ROTMI: res_o = shr_word(word_i, 6'd0 - imm_i[5:0]);
      default:   res_o = '0;
    endcase
  end

endmodule

// File: rtl/fx2_pipe.sv
// FX2 even-pipe execution stage: four word shifters feeding a fixed-latency
// valid/rt/data pipeline with flush and synchronous reset. LATENCY is 2..7.
module fx2_pipe
  import fx2_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int RT_W    = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [2:0]              issue_op,
  input  logic [RT_W-1:0]         issue_rt,
  input  logic [QUAD_W-1:0]       ra,
  input  logic [QUAD_W-1:0]       rb,
  input  logic [6:0]              imme7,
  input  logic                    flush,
  output logic [LATENCY-1:0]      stage_valid,
  output logic [LATENCY*RT_W-1:0] stage_rt,
  output logic                    wb_valid,
  output logic [RT_W-1:0]         wb_rt,
  output logic [QUAD_W-1:0]       wb_data
);

  logic [QUAD_W-1:0]  result_d;
  logic [LATENCY-1:0] vld_d;
  logic [LATENCY-1:0] vld_q;
  logic [RT_W-1:0]    rt_q   [LATENCY];
  logic [QUAD_W-1:0]  data_q [LATENCY];

  // Word j sits at big-endian bits [32j:32j+31], i.e. the j-th word from the MSB end.
  for (genvar j = 0; j < 4; j++) begin : g_word
    fx2_word_shift u_ws (
      .word_i (ra[QUAD_W-WORD_W*(j+1) +: WORD_W]),
      .op_i   (issue_op),
      .cnt_i  (rb[QUAD_W-WORD_W*(j+1) +: 6]),
      .imm_i  (imme7),
      .res_o  (result_d[QUAD_W-WORD_W*(j+1) +: WORD_W])
    );
  end

  logic unused_rb;
  assign unused_rb = ^{rb[127:102], rb[95:70], rb[63:38], rb[31:6]};

  assign vld_d = flush ? '0 : {vld_q[LATENCY-2:0], issue_valid};

  // Stage 1 captures the issue result; later stages are pure delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        rt_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      if (issue_valid) begin
        rt_q[0]   <= issue_rt;
        data_q[0] <= result_d;
      end
      for (int i = 1; i < LATENCY; i++) begin
        rt_q[i]   <= rt_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage_rt
    assign stage_rt[i*RT_W +: RT_W] = rt_q[i];
  end

  assign stage_valid = vld_q;
  assign wb_valid    = vld_q[LATENCY-1];
  assign wb_rt       = rt_q[LATENCY-1];
  assign wb_data     = data_q[LATENCY-1];

endmodule

// File: tb/tb_fx2_pipe.sv
// Directed-vector bench for fx2_pipe with hand-computed expected results.
module tb_fx2_pipe;

  localparam int LAT  = 4;
  localparam int RT_W = 7;

  logic                clk;
  logic                reset;
  logic                issue_valid;
  logic [2:0]          issue_op;
  logic [RT_W-1:0]     issue_rt;
  logic [127:0]        ra;
  logic [127:0]        rb;
  logic [6:0]          imme7;
  logic                flush;
  logic [LAT-1:0]      stage_valid;
  logic [LAT*RT_W-1:0] stage_rt;
  logic                wb_valid;
  logic [RT_W-1:0]     wb_rt;
  logic [127:0]        wb_data;

  int n_checks = 0;
  int n_errors = 0;

  fx2_pipe #(.LATENCY(LAT), .RT_W(RT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_rt    (issue_rt),
    .ra          (ra),
    .rb          (rb),
    .imme7       (imme7),
    .flush       (flush),
    .stage_valid (stage_valid),
    .stage_rt    (stage_rt),
    .wb_valid    (wb_valid),
    .wb_rt       (wb_rt),
    .wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] quad(input logic [31:0] w);
    return {w, w, w, w};
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [6:0] rt,
                       input logic [127:0] a, input logic [127:0] b, input logic [6:0] imm);
    issue_valid = v;
    issue_op    = op;
    issue_rt    = rt;
    ra          = a;
    rb          = b;
    imme7       = imm;
  endtask

  // One isolated instruction: checks latency, intermediate state and result.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [127:0] a,
                         input logic [127:0] b, input logic [6:0] imm,
                         input logic [6:0] rt, input logic [127:0] exp);
    drive(1'b1, op, rt, a, b, imm);
    step();
    drive(1'b0, 3'd0, 7'd0, '0, '0, 7'd0);
    check({tag, "_sv0"}, 128'(stage_valid), 128'(4'b0001));
    check({tag, "_srt0"}, 128'(stage_rt[RT_W-1:0]), 128'(rt));
    for (int k = 1; k < LAT; k++) begin
      check({tag, "_early"}, 128'(wb_valid), 128'(1'b0));
      step();
    end
    check({tag, "_wbv"}, 128'(wb_valid), 128'(1'b1));
    check({tag, "_wbrt"}, 128'(wb_rt), 128'(rt));
    check({tag, "_data"}, wb_data, exp);
    step();
    check({tag, "_after"}, 128'(wb_valid), 128'(1'b0));
  endtask

  initial begin
    flush = 1'b0;
    reset = 1'b1;
    drive(1'b1, 3'd1, 7'd5, quad(32'hFFFF_FFFF), '0, 7'd1);

    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_wbv", 128'(wb_valid), 128'(1'b0));
      check("rst_sv", 128'(stage_valid), 128'(0));
      check("rst_data", wb_data, '0);
    end
    reset = 1'b0;
    drive(1'b0, 3'd0, 7'd0, '0, '0, 7'd0);
    for (int k = 0; k < LAT; k++) begin
      step();
      check("idle_wbv", 128'(wb_valid), 128'(1'b0));
      check("idle_data", wb_data, '0);
    end

    run_one("shli1", 3'd1, quad(32'h8000_0001), '0, 7'd1, 7'd5, quad(32'h0000_0002));
    run_one("shli63", 3'd1, quad(32'h8000_0001), '0, 7'h7F, 7'd6, '0);
    run_one("shli31", 3'd1, quad(32'h0000_0001), '0, 7'd31, 7'd7, quad(32'h8000_0000));
    run_one("shl", 3'd0, quad(32'h0000_0001),
            {32'd1, 32'd31, 32'd32, 32'hFFFF_FFC0}, 7'd0, 7'd8,
            {32'h0000_0002, 32'h8000_0000, 32'h0, 32'h0000_0001});
    run_one("rot", 3'd2, quad(32'h1234_5678), {32'd0, 32'd4, 32'd36, 32'd32}, 7'd0, 7'd9,
            {32'h1234_5678, 32'h2345_6781, 32'h2345_6781, 32'h1234_5678});
    run_one("roti", 3'd3, quad(32'h1234_5678), '0, 7'd8, 7'd10, quad(32'h3456_7812));
    run_one("rotm4", 3'd4, quad(32'hF000_0000), quad(32'hFFFF_FFFC), 7'd0, 7'd11,
            quad(32'h0F00_0000));
    run_one("rotm0", 3'd4, quad(32'hF000_0000), '0, 7'd0, 7'd12, quad(32'hF000_0000));
    run_one("rotmi4", 3'd5, quad(32'hF000_0000), '0, 7'h7C, 7'd13, quad(32'h0F00_0000));
    run_one("rotmi32", 3'd5, quad(32'hF000_0000), '0, 7'h60, 7'd14, '0);
    run_one("rsvd6", 3'd6, quad(32'hDEAD_BEEF), quad(32'd1), 7'd3, 7'd15, '0);

    // Bubble between two issues.
    drive(1'b1, 3'd3, 7'd2, quad(32'h1234_5678), '0, 7'd8);
    step();
    drive(1'b0, 3'd0, 7'd0, '0, '0, 7'd0);
    step();
    drive(1'b1, 3'd3, 7'd3, quad(32'h1234_5678), '0, 7'd4);
    step();
    drive(1'b0, 3'd0, 7'd0, '0, '0, 7'd0);
    check("bub_sv", 128'(stage_valid), 128'(4'b0101));
    check("bub_srt0", 128'(stage_rt[RT_W-1:0]), 128'(7'd3));
    check("bub_srt2", 128'(stage_rt[2*RT_W +: RT_W]), 128'(7'd2));
    step();
    check("bub_wb1v", 128'(wb_valid), 128'(1'b1));
    check("bub_wb1rt", 128'(wb_rt), 128'(7'd2));
    step();
    check("bub_gap", 128'(wb_valid), 128'(1'b0));
    step();
    check("bub_wb2v", 128'(wb_valid), 128'(1'b1));
    check("bub_wb2d", wb_data, quad(32'h2345_6781));
    step();

    // Back-to-back issue with flush on the third.
    for (int r = 1; r <= 4; r++) begin
      drive(1'b1, 3'd3, 7'(r), quad(32'h1234_5678), '0, 7'd8);
      flush = (r == 3);
      step();
      flush = 1'b0;
      if (r == 2) check("b2b_sv", 128'(stage_valid), 128'(4'b0011));
      if (r == 3) begin
        check("fl_sv", 128'(stage_valid), 128'(0));
        check("fl_wbv", 128'(wb_valid), 128'(1'b0));
      end
    end
    drive(1'b0, 3'd0, 7'd0, '0, '0, 7'd0);
    check("fl_post_sv", 128'(stage_valid), 128'(4'b0001));
    for (int e = 5; e <= 9; e++) begin
      step();
      check("fl_wbv_seq", 128'(wb_valid), 128'(e == 4 + LAT - 1));
      if (e == 4 + LAT - 1) begin
        check("fl_wbrt", 128'(wb_rt), 128'(7'd4));
        check("fl_data", wb_data, quad(32'h3456_7812));
      end
    end

    // Reset (with flush) in the middle of an operation drops it.
    drive(1'b1, 3'd1, 7'd9, quad(32'h0000_0001), '0, 7'd1);
    step();
    drive(1'b0, 3'd0, 7'd0, '0, '0, 7'd0);
    step();
    reset = 1'b1;
    flush = 1'b1;
    step();
    reset = 1'b0;
    flush = 1'b0;
    check("mrst_sv", 128'(stage_valid), 128'(0));
    check("mrst_data", wb_data, '0);
    check("mrst_wbrt", 128'(wb_rt), 128'(0));
    for (int k = 0; k < LAT; k++) begin
      step();
      check("mrst_wbv", 128'(wb_valid), 128'(1'b0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
